// File: rtl/basilisk_mult_normalize.sv
// Output stage for one stream: MODE 0 pass-through, 1 single register, 2 skid (two entries).
// Latency 0/1/1 cycles; payload is held stable while out_vld && !out_rdy, occ reports held entries.
module basilisk_flow_stage #(
   parameter int MODE = 1,
   parameter int W    = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat,
   output logic [1:0]   occ
);

   generate
      if (MODE == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign out_vld = in_vld;
         assign in_rdy  = out_rdy;
         assign out_dat = in_dat;
         assign occ     = 2'd0;
      end else if (MODE == 1) begin : g_reg
         logic         vld_q, vld_d;
         logic [W-1:0] dat_q, dat_d;

         always_comb begin
            vld_d = vld_q;
            dat_d = dat_q;
            if (!vld_q || out_rdy) begin
               vld_d = in_vld;
               dat_d = in_dat;
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               vld_q <= 1'b0;
               dat_q <= '0;
            end else begin
               vld_q <= vld_d;
               dat_q <= dat_d;
            end
         end

         assign in_rdy  = !vld_q || out_rdy;
         assign out_vld = vld_q;
         assign out_dat = dat_q;
         assign occ     = {1'b0, vld_q};
      end else begin : g_skid
         logic         vld_q, vld_d, sk_vld_q, sk_vld_d;
         logic [W-1:0] dat_q, dat_d, sk_dat_q, sk_dat_d;

         // in_rdy comes only from the skid flop, so ready never depends on out_rdy combinationally.
         always_comb begin
            vld_d    = vld_q;
            dat_d    = dat_q;
            sk_vld_d = sk_vld_q;
            sk_dat_d = sk_dat_q;
            if (!vld_q || out_rdy) begin
               if (sk_vld_q) begin
                  vld_d    = 1'b1;
                  dat_d    = sk_dat_q;
                  sk_vld_d = 1'b0;
               end else begin
                  vld_d = in_vld;
                  dat_d = in_dat;
               end
            end else if (in_vld && !sk_vld_q) begin
               sk_vld_d = 1'b1;
               sk_dat_d = in_dat;
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               vld_q    <= 1'b0;
               dat_q    <= '0;
               sk_vld_q <= 1'b0;
               sk_dat_q <= '0;
            end else begin
               vld_q    <= vld_d;
               dat_q    <= dat_d;
               sk_vld_q <= sk_vld_d;
               sk_dat_q <= sk_dat_d;
            end
         end

         assign in_rdy  = !sk_vld_q;
         assign out_vld = vld_q;
         assign out_dat = dat_q;
         assign occ     = {1'b0, vld_q} + {1'b0, sk_vld_q};
      end
   endgenerate

endmodule

// Normalizes and RNE-rounds a raw FP32 product (FTZ), steering it to writeback or the fused-add stage.
// Latency 2 (normalize, round) plus the output stage; strict in-order, stalls on either output or the macc cap.
module basilisk_mult_normalize #(
   parameter int OUTPUT_REGISTER_MODE = 1,
   parameter int MACC_MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mult_operation_command_vld,
   output logic        mult_operation_command_rdy,
   input  logic        mult_operation_command_sign,
   input  logic [9:0]  mult_operation_command_exponent,
   input  logic [47:0] mult_operation_command_mantissa,
   input  logic        mult_operation_command_nan,
   input  logic        mult_operation_command_inf,
   input  logic        mult_operation_command_zero,
   input  logic        mult_operation_command_enable_macc,
   input  logic [31:0] mult_operation_command_c,
   input  logic [3:0]  mult_operation_command_conditions_c,
   input  logic [4:0]  mult_operation_command_dest_reg_addr,
   input  logic [7:0]  mult_operation_command_dest_offset_addr,
   output logic        mult_writeback_command_vld,
   input  logic        mult_writeback_command_rdy,
   output logic [4:0]  mult_writeback_command_dest_reg_addr,
   output logic [7:0]  mult_writeback_command_dest_offset_addr,
   output logic [31:0] mult_writeback_command_value,
   output logic        mult_add_command_vld,
   input  logic        mult_add_command_rdy,
   output logic [31:0] mult_add_command_a,
   output logic [31:0] mult_add_command_b,
   output logic [3:0]  mult_add_command_conditions_c,
   output logic [4:0]  mult_add_command_dest_reg_addr,
   output logic [7:0]  mult_add_command_dest_offset_addr,
   input  logic        macc_retire,
   output logic        macc_busy
);

   typedef struct packed {
      logic        sign;
      logic [10:0] exp;
      logic [45:0] m;
      logic        sticky;
      logic        nan;
      logic        inf;
      logic        zero;
      logic        macc;
      logic [31:0] c;
      logic [3:0]  cond;
      logic [4:0]  dest_reg;
      logic [7:0]  dest_off;
   } norm_t;

   typedef struct packed {
      logic        macc;
      logic [31:0] res;
      logic [31:0] c;
      logic [3:0]  cond;
      logic [4:0]  dest_reg;
      logic [7:0]  dest_off;
   } rnd_t;

   localparam int WB_W  = 45;
   localparam int ADD_W = 81;

   norm_t       s1_q, s1_d;
   rnd_t        s2_q, s2_d;
   logic        s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
   logic        s1_adv, s2_adv, s2_fire, in_fire;
   logic [3:0]  cnt_q, cnt_d;
   logic [4:0]  pending;
   logic        at_limit, add_hs, retire_ok;
   logic        wb_in_vld, wb_in_rdy, add_in_vld, add_in_rdy;
   logic [1:0]  wb_occ, add_occ;
   logic [WB_W-1:0]  wb_in_dat, wb_out_dat;
   logic [ADD_W-1:0] add_in_dat, add_out_dat;
   logic [22:0] frac;
   logic        guard, sticky, rnd_up;
   logic [23:0] frac_sum;
   logic [10:0] exp_r;
   logic [31:0] res;

   assign s2_adv  = !s2_vld_q || s2_fire;
   assign s1_adv  = !s1_vld_q || s2_adv;
   assign in_fire = mult_operation_command_vld && s1_adv;
   assign mult_operation_command_rdy = s1_adv;

   always_comb begin
      s1_vld_d = s1_vld_q;
      s1_d     = s1_q;
      if (s1_adv) begin
         s1_vld_d    = in_fire;
         s1_d.sign   = mult_operation_command_sign;
         s1_d.nan    = mult_operation_command_nan;
         s1_d.inf    = mult_operation_command_inf;
         s1_d.zero   = mult_operation_command_zero;
         s1_d.macc   = mult_operation_command_enable_macc;
         s1_d.c      = mult_operation_command_c;
         s1_d.cond   = mult_operation_command_conditions_c;
         s1_d.dest_reg = mult_operation_command_dest_reg_addr;
         s1_d.dest_off = mult_operation_command_dest_offset_addr;
         if (mult_operation_command_mantissa[47]) begin
            s1_d.exp    = {mult_operation_command_exponent[9], mult_operation_command_exponent} + 11'd1;
            s1_d.m      = mult_operation_command_mantissa[46:1];
            s1_d.sticky = mult_operation_command_mantissa[0];
         end else begin
            s1_d.exp    = {mult_operation_command_exponent[9], mult_operation_command_exponent};
            s1_d.m      = mult_operation_command_mantissa[45:0];
            s1_d.sticky = 1'b0;
         end
      end
   end

   // Round to nearest even on the 23-bit fraction below the hidden bit; flags win over arithmetic.
   always_comb begin
      frac     = s1_q.m[45:23];
      guard    = s1_q.m[22];
      sticky   = (|s1_q.m[21:0]) | s1_q.sticky;
      rnd_up   = guard & (sticky | frac[0]);
      frac_sum = {1'b0, frac} + {23'd0, rnd_up};
      exp_r    = s1_q.exp + {10'd0, frac_sum[23]};
      if (s1_q.nan)
         res = 32'h7FC0_0000;
      else if (s1_q.inf)
         res = {s1_q.sign, 8'hFF, 23'd0};
      else if (s1_q.zero)
         res = {s1_q.sign, 31'd0};
      else if ($signed(exp_r) >= 11'sd255)
         res = {s1_q.sign, 8'hFF, 23'd0};
      else if ($signed(exp_r) <= 11'sd0)
         res = {s1_q.sign, 31'd0};
      else
         res = {s1_q.sign, exp_r[7:0], frac_sum[22:0]};
   end

   always_comb begin
      s2_vld_d = s2_vld_q;
      s2_d     = s2_q;
      if (s2_adv) begin
         s2_vld_d    = s1_vld_q;
         s2_d.macc   = s1_q.macc;
         s2_d.res    = res;
         s2_d.c      = s1_q.c;
         s2_d.cond   = s1_q.cond;
         s2_d.dest_reg = s1_q.dest_reg;
         s2_d.dest_off = s1_q.dest_off;
      end
   end

   // An op only leaves when the other output holds nothing, which keeps both streams in program order.
   assign pending    = {1'b0, cnt_q} + {3'b000, add_occ};
   assign at_limit   = pending >= 5'(MACC_MAX_OUTSTANDING);
   assign add_in_vld = s2_vld_q && s2_q.macc && !at_limit && (wb_occ == 2'd0);
   assign wb_in_vld  = s2_vld_q && !s2_q.macc && (add_occ == 2'd0);
   assign s2_fire    = (add_in_vld && add_in_rdy) || (wb_in_vld && wb_in_rdy);
   assign wb_in_dat  = {s2_q.dest_reg, s2_q.dest_off, s2_q.res};
   assign add_in_dat = {s2_q.res, s2_q.c, s2_q.cond, s2_q.dest_reg, s2_q.dest_off};

   assign add_hs    = mult_add_command_vld && mult_add_command_rdy;
   assign retire_ok = macc_retire && (cnt_q != 4'd0);

   always_comb begin
      cnt_d = cnt_q;
      if (add_hs && !retire_ok)
         cnt_d = cnt_q + 4'd1;
      else if (!add_hs && retire_ok)
         cnt_d = cnt_q - 4'd1;
   end

   assign macc_busy = (cnt_q != 4'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
         s1_q     <= '0;
         s2_q     <= '0;
         cnt_q    <= 4'd0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s2_vld_q <= s2_vld_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         cnt_q    <= cnt_d;
      end
   end

   a_retire_underflow: assert property (@(posedge clk) disable iff (!rst)
      !(macc_retire && (cnt_q == 4'd0)));

   basilisk_flow_stage #(.MODE(OUTPUT_REGISTER_MODE), .W(WB_W)) u_wb_stage (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (wb_in_vld),
      .in_rdy  (wb_in_rdy),
      .in_dat  (wb_in_dat),
      .out_vld (mult_writeback_command_vld),
      .out_rdy (mult_writeback_command_rdy),
      .out_dat (wb_out_dat),
      .occ     (wb_occ)
   );

   basilisk_flow_stage #(.MODE(OUTPUT_REGISTER_MODE), .W(ADD_W)) u_add_stage (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (add_in_vld),
      .in_rdy  (add_in_rdy),
      .in_dat  (add_in_dat),
      .out_vld (mult_add_command_vld),
      .out_rdy (mult_add_command_rdy),
      .out_dat (add_out_dat),
      .occ     (add_occ)
   );

   assign {mult_writeback_command_dest_reg_addr, mult_writeback_command_dest_offset_addr,
           mult_writeback_command_value} = wb_out_dat;
   assign {mult_add_command_a, mult_add_command_b, mult_add_command_conditions_c,
           mult_add_command_dest_reg_addr, mult_add_command_dest_offset_addr} = add_out_dat;

endmodule

// File: tb/tb_basilisk_mult_normalize.sv
// Directed bench for basilisk_mult_normalize: registered outputs, macc cap of 2.
module tb_basilisk_mult_normalize;

   localparam logic [2:0] F_NONE = 3'b000;
   localparam logic [2:0] F_NAN  = 3'b100;
   localparam logic [2:0] F_INF  = 3'b010;
   localparam logic [2:0] F_ZERO = 3'b001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        cmd_vld, cmd_rdy, cmd_sign, cmd_nan, cmd_inf, cmd_zero, cmd_macc;
   logic [9:0]  cmd_exp;
   logic [47:0] cmd_mant;
   logic [31:0] cmd_c;
   logic [3:0]  cmd_cond;
   logic [4:0]  cmd_reg;
   logic [7:0]  cmd_off;
   logic        wb_vld, wb_rdy;
   logic [4:0]  wb_reg;
   logic [7:0]  wb_off;
   logic [31:0] wb_value;
   logic        add_vld, add_rdy;
   logic [31:0] add_a, add_b;
   logic [3:0]  add_cond;
   logic [4:0]  add_reg;
   logic [7:0]  add_off;
   logic        macc_retire, macc_busy;

   int checks = 0;
   int failures = 0;
   int wb_hs = 0;
   int add_hs = 0;

   basilisk_mult_normalize #(.OUTPUT_REGISTER_MODE(1), .MACC_MAX_OUTSTANDING(2)) dut (
      .clk                                     (clk),
      .rst                                     (rst),
      .mult_operation_command_vld              (cmd_vld),
      .mult_operation_command_rdy              (cmd_rdy),
      .mult_operation_command_sign             (cmd_sign),
      .mult_operation_command_exponent         (cmd_exp),
      .mult_operation_command_mantissa         (cmd_mant),
      .mult_operation_command_nan              (cmd_nan),
      .mult_operation_command_inf              (cmd_inf),
      .mult_operation_command_zero             (cmd_zero),
      .mult_operation_command_enable_macc      (cmd_macc),
      .mult_operation_command_c                (cmd_c),
      .mult_operation_command_conditions_c     (cmd_cond),
      .mult_operation_command_dest_reg_addr    (cmd_reg),
      .mult_operation_command_dest_offset_addr (cmd_off),
      .mult_writeback_command_vld              (wb_vld),
      .mult_writeback_command_rdy              (wb_rdy),
      .mult_writeback_command_dest_reg_addr    (wb_reg),
      .mult_writeback_command_dest_offset_addr (wb_off),
      .mult_writeback_command_value            (wb_value),
      .mult_add_command_vld                    (add_vld),
      .mult_add_command_rdy                    (add_rdy),
      .mult_add_command_a                      (add_a),
      .mult_add_command_b                      (add_b),
      .mult_add_command_conditions_c           (add_cond),
      .mult_add_command_dest_reg_addr          (add_reg),
      .mult_add_command_dest_offset_addr       (add_off),
      .macc_retire                             (macc_retire),
      .macc_busy                               (macc_busy)
   );

   always @(posedge clk) begin
      if (rst) begin
         if (wb_vld && wb_rdy) wb_hs++;
         if (add_vld && add_rdy) add_hs++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m, input logic [2:0] fl,
                       input logic macc, input logic [31:0] c, input logic [3:0] cond,
                       input logic [4:0] rg, input logic [7:0] off);
      int n = 0;
      cmd_sign = s; cmd_exp = e; cmd_mant = m;
      {cmd_nan, cmd_inf, cmd_zero} = fl;
      cmd_macc = macc; cmd_c = c; cmd_cond = cond; cmd_reg = rg; cmd_off = off;
      cmd_vld = 1'b1;
      @(negedge clk);
      while (!cmd_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_rdy", cmd_rdy, 1);
      @(posedge clk);
      #1 cmd_vld = 1'b0;
   endtask

   task automatic expect_wb(input string tag, input logic [31:0] v, input logic [4:0] rg, input logic [7:0] off);
      int n = 0;
      while (!wb_vld && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_vld"}, wb_vld, 1);
      check({tag, "_value"}, wb_value, v);
      check({tag, "_reg"}, wb_reg, rg);
      check({tag, "_off"}, wb_off, off);
      check({tag, "_no_add"}, add_vld, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_add(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [3:0] cond,
                             input logic [4:0] rg, input logic [7:0] off);
      int n = 0;
      while (!add_vld && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_vld"}, add_vld, 1);
      check({tag, "_a"}, add_a, a);
      check({tag, "_b"}, add_b, b);
      check({tag, "_cond"}, add_cond, cond);
      check({tag, "_reg"}, add_reg, rg);
      check({tag, "_off"}, add_off, off);
      check({tag, "_no_wb"}, wb_vld, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic retire_pulse();
      macc_retire = 1'b1;
      @(posedge clk);
      #1 macc_retire = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_seen;
      int h0;
      rst = 1'b0; cmd_vld = 1'b0; cmd_sign = 1'b0; cmd_exp = '0; cmd_mant = '0;
      cmd_nan = 1'b0; cmd_inf = 1'b0; cmd_zero = 1'b0; cmd_macc = 1'b0;
      cmd_c = '0; cmd_cond = '0; cmd_reg = '0; cmd_off = '0;
      wb_rdy = 1'b1; add_rdy = 1'b1; macc_retire = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_wb_vld", wb_vld, 0);
      check("rst_add_vld", add_vld, 0);
      check("rst_busy", macc_busy, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rel_cmd_rdy", cmd_rdy, 1);
      check("rel_wb_vld", wb_vld, 0);
      check("rel_add_vld", add_vld, 0);
      check("rel_busy", macc_busy, 0);
      @(posedge clk);
      #1;

      // 1.5 * 1.5 with exact latency: valid appears two edges after the input handshake edge, plus the output register
      send(1'b0, 10'd127, 48'h9000_0000_0000, F_NONE, 1'b0, 32'h0, 4'h0, 5'd1, 8'h11);
      @(negedge clk);
      check("lat_c1", wb_vld, 0);
      @(negedge clk);
      check("lat_c2", wb_vld, 0);
      @(negedge clk);
      check("lat_c3", wb_vld, 1);
      expect_wb("mul15", 32'h4010_0000, 5'd1, 8'h11);

      send(1'b1, 10'd127, 48'h9000_0000_0000, F_NONE, 1'b0, 32'h0, 4'h0, 5'd2, 8'h12);
      expect_wb("mul15_neg", 32'hC010_0000, 5'd2, 8'h12);
      send(1'b0, 10'd127, 48'h4000_0040_0000, F_NONE, 1'b0, 32'h0, 4'h0, 5'd3, 8'h13);
      expect_wb("tie_even", 32'h3F80_0000, 5'd3, 8'h13);
      send(1'b0, 10'd127, 48'h4000_00C0_0000, F_NONE, 1'b0, 32'h0, 4'h0, 5'd4, 8'h14);
      expect_wb("tie_odd", 32'h3F80_0002, 5'd4, 8'h14);
      send(1'b0, 10'd127, 48'h4000_0040_0001, F_NONE, 1'b0, 32'h0, 4'h0, 5'd5, 8'h15);
      expect_wb("above_half", 32'h3F80_0001, 5'd5, 8'h15);
      send(1'b0, 10'd127, 48'h8000_0080_0001, F_NONE, 1'b0, 32'h0, 4'h0, 5'd6, 8'h16);
      expect_wb("shift_sticky", 32'h4000_0001, 5'd6, 8'h16);
      send(1'b0, 10'd127, 48'h7FFF_FFC0_0000, F_NONE, 1'b0, 32'h0, 4'h0, 5'd7, 8'h17);
      expect_wb("round_carry", 32'h4000_0000, 5'd7, 8'h17);
      send(1'b0, 10'd254, 48'h8000_0000_0000, F_NONE, 1'b0, 32'h0, 4'h0, 5'd8, 8'h18);
      expect_wb("overflow", 32'h7F80_0000, 5'd8, 8'h18);
      send(1'b1, 10'd300, 48'h4000_0000_0000, F_NONE, 1'b0, 32'h0, 4'h0, 5'd9, 8'h19);
      expect_wb("overflow_neg", 32'hFF80_0000, 5'd9, 8'h19);
      send(1'b0, 10'd0, 48'h4000_0000_0000, F_NONE, 1'b0, 32'h0, 4'h0, 5'd10, 8'h1A);
      expect_wb("underflow", 32'h0000_0000, 5'd10, 8'h1A);
      send(1'b1, 10'h3FB, 48'h4000_0000_0000, F_NONE, 1'b0, 32'h0, 4'h0, 5'd11, 8'h1B);
      expect_wb("underflow_neg", 32'h8000_0000, 5'd11, 8'h1B);
      send(1'b1, 10'd127, 48'h4000_0000_0000, F_NAN, 1'b0, 32'h0, 4'h0, 5'd12, 8'h1C);
      expect_wb("nan", 32'h7FC0_0000, 5'd12, 8'h1C);
      send(1'b1, 10'd127, 48'h4000_0000_0000, F_INF, 1'b0, 32'h0, 4'h0, 5'd13, 8'h1D);
      expect_wb("inf_flag", 32'hFF80_0000, 5'd13, 8'h1D);
      send(1'b1, 10'd127, 48'h4000_0000_0000, F_ZERO, 1'b0, 32'h0, 4'h0, 5'd14, 8'h1E);
      expect_wb("zero_flag", 32'h8000_0000, 5'd14, 8'h1E);

      // macc op stalled on the add output must hold back a later writeback op
      add_rdy = 1'b0;
      send(1'b0, 10'd127, 48'h4000_0000_0000, F_NONE, 1'b1, 32'hCAFE_F00D, 4'h3, 5'd20, 8'h21);
      send(1'b0, 10'd127, 48'h9000_0000_0000, F_NONE, 1'b0, 32'h0, 4'h0, 5'd21, 8'h22);
      h0 = wb_hs;
      n_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (wb_vld) n_seen++;
      end
      check("ord_wb_held", n_seen, 0);
      check("ord_add_vld", add_vld, 1);
      check("ord_add_a_stable", add_a, 32'h3F80_0000);
      add_rdy = 1'b1;
      expect_add("ord_macc", 32'h3F80_0000, 32'hCAFE_F00D, 4'h3, 5'd20, 8'h21);
      check("ord_no_wb_before_add", wb_hs - h0, 0);
      check("ord_busy_one", macc_busy, 1);
      expect_wb("ord_wb", 32'h4010_0000, 5'd21, 8'h22);
      retire_pulse();
      check("ord_busy_clear", macc_busy, 0);

      // outstanding cap of 2: third macc op waits for a retire
      h0 = add_hs;
      send(1'b0, 10'd127, 48'h4000_0000_0000, F_NONE, 1'b1, 32'h1111_1111, 4'h1, 5'd1, 8'h31);
      send(1'b0, 10'd127, 48'h9000_0000_0000, F_NONE, 1'b1, 32'h2222_2222, 4'h2, 5'd2, 8'h32);
      send(1'b0, 10'd127, 48'h4000_00C0_0000, F_NONE, 1'b1, 32'h0BAD_BEEF, 4'h9, 5'd3, 8'h33);
      repeat (8) @(negedge clk);
      check("lim_two_done", add_hs - h0, 2);
      check("lim_add_held", add_vld, 0);
      check("lim_busy", macc_busy, 1);
      retire_pulse();
      expect_add("lim_third", 32'h3F80_0002, 32'h0BAD_BEEF, 4'h9, 5'd3, 8'h33);
      check("lim_three_done", add_hs - h0, 3);
      check("lim_busy_cnt2", macc_busy, 1);
      retire_pulse();
      check("lim_busy_cnt1", macc_busy, 1);
      retire_pulse();
      check("lim_busy_cnt0", macc_busy, 0);

      // reset while ops are in flight
      send(1'b0, 10'd127, 48'h4000_0000_0000, F_NONE, 1'b1, 32'h5555_AAAA, 4'h5, 5'd9, 8'h41);
      expect_add("rst_pre_macc", 32'h3F80_0000, 32'h5555_AAAA, 4'h5, 5'd9, 8'h41);
      check("rst_pre_busy", macc_busy, 1);
      h0 = wb_hs;
      send(1'b0, 10'd127, 48'h9000_0000_0000, F_NONE, 1'b0, 32'h0, 4'h0, 5'd10, 8'h42);
      send(1'b0, 10'd127, 48'h4000_00C0_0000, F_NONE, 1'b0, 32'h0, 4'h0, 5'd11, 8'h43);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_wb_vld", wb_vld, 0);
      check("mid_rst_add_vld", add_vld, 0);
      check("mid_rst_busy", macc_busy, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      n_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (wb_vld || add_vld) n_seen++;
      end
      check("post_rst_no_output", n_seen, 0);
      check("post_rst_no_wb_hs", wb_hs - h0, 0);
      check("post_rst_busy", macc_busy, 0);
      check("post_rst_cmd_rdy", cmd_rdy, 1);
      @(posedge clk);
      #1;
      send(1'b0, 10'd127, 48'h4000_0040_0000, F_NONE, 1'b0, 32'h0, 4'h0, 5'd12, 8'h44);
      expect_wb("post_rst_op", 32'h3F80_0000, 5'd12, 8'h44);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
